// File: rtl/module_pc_unit.sv
// Program counter unit: next-PC selection, fetch handshake and trap redirect.
// Optional feature: define MISALIGN_TRAP_EN to turn a misaligned fetch target
// into a trap (with a misaligned pulse) instead of silently clearing bits [1:0].
module module_pc_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] TRAP_ADDR  = XLEN'(32'h0000_0100)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            stall,
   input  logic            is_jmp,
   input  logic            alu_not,
   input  logic [1:0]      is_branch,
   input  logic [XLEN-1:0] alu_out,
   input  logic [XLEN-1:0] imm,
   input  logic            trap,
   input  logic            imem_ready,
   output logic [XLEN-1:0] addr,
   output logic            imem_valid,
   output logic [XLEN-1:0] epc,
   output logic            trap_taken,
   output logic            misaligned
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_TRAP  = 2'd2;

   logic [1:0]      state;
   logic            taken;
   logic [1:0]      sel;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] next_addr;
   logic            accept;
   logic            mis_hit;
   logic            trap_go;

   // Branch condition, select code and raw target (all sums wrap modulo 2^XLEN)
   always_comb begin
      taken = alu_not ? (alu_out == '0) : (alu_out != '0);
      sel   = is_jmp ? {1'b0, taken} : is_branch;
      case (sel)
         2'd0:    target = addr + XLEN'(4);
         2'd1:    target = addr + imm;
         2'd2:    target = {alu_out[XLEN-1:1], 1'b0};
         default: target = RESET_ADDR;
      endcase
   end

   assign accept     = (state == ST_FETCH) && imem_ready && !stall;
   assign imem_valid = (state == ST_FETCH);

`ifdef MISALIGN_TRAP_EN
   // A misaligned accepted target is redirected to the trap vector
   assign mis_hit   = accept && (target[1:0] != 2'b00);
   assign next_addr = target;
`else
   // Without misalignment trapping the low two bits are simply cleared
   assign mis_hit   = 1'b0;
   assign next_addr = target & ~XLEN'(3);
`endif

   // Trap wins over any branch/jump; it does not depend on imem_ready
   assign trap_go = (state == ST_FETCH) && !stall && (trap || mis_hit);

   logic mis_q;

   // State machine, PC/EPC registers and one-cycle status pulses
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= ST_BOOT;
         addr       <= RESET_ADDR;
         epc        <= '0;
         trap_taken <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         trap_taken <= 1'b0;
         mis_q      <= 1'b0;
         case (state)
            ST_BOOT: begin
               state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (trap_go) begin
                  epc        <= addr;
                  addr       <= TRAP_ADDR;
                  state      <= ST_TRAP;
                  trap_taken <= 1'b1;
                  mis_q      <= mis_hit;
               end else if (accept) begin
                  addr <= next_addr;
               end
            end
            ST_TRAP: begin
               if (!stall) state <= ST_FETCH;
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

`ifdef MISALIGN_TRAP_EN
   assign misaligned = mis_q;
`else
   assign misaligned = 1'b0;
   // mis_q never sets in this build; fold it into an unused-safe reduction
   logic unused_mis;
   assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_module_pc_unit.sv
// Directed self-checking bench for module_pc_unit.
// Expectations follow MISALIGN_TRAP_EN the same way the design does.
module tb_module_pc_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        is_jmp;
   logic        alu_not;
   logic [1:0]  is_branch;
   logic [31:0] alu_out;
   logic [31:0] imm;
   logic        trap;
   logic        imem_ready;
   logic [31:0] addr;
   logic        imem_valid;
   logic [31:0] epc;
   logic        trap_taken;
   logic        misaligned;

   int n_checks = 0;
   int n_fail   = 0;

   module_pc_unit dut (
      .clock(clock), .reset(reset), .stall(stall), .is_jmp(is_jmp),
      .alu_not(alu_not), .is_branch(is_branch), .alu_out(alu_out),
      .imm(imm), .trap(trap), .imem_ready(imem_ready), .addr(addr),
      .imem_valid(imem_valid), .epc(epc), .trap_taken(trap_taken),
      .misaligned(misaligned)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic set_idle();
      stall = 0; is_jmp = 0; alu_not = 0; is_branch = 2'd0;
      alu_out = 32'h0; imm = 32'h0; trap = 0; imem_ready = 1;
   endtask

   // Jump the PC to an aligned address via the JALR path (state must be FETCH)
   task automatic go_to(input logic [31:0] a);
      set_idle();
      is_branch = 2'd2; alu_out = a;
      @(negedge clock);
      set_idle();
   endtask

   task automatic test_reset();
      set_idle();
      reset = 0;
      repeat (2) @(negedge clock);
      n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want %h", addr, 32'h0); end
      n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", imem_valid); end
      n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL rst_epc: got %h want 0", epc); end
      n_checks++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL rst_trap_taken: got %b want 0", trap_taken); end
      n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_misaligned: got %b want 0", misaligned); end
      reset = 1;
      #1;
      n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b want 0", imem_valid); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         n_checks++; if (addr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, addr, 32'(4 * i)); end
         n_checks++; if (imem_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b want 1", i, imem_valid); end
      end
   endtask

   task automatic test_branch();
      go_to(32'h40);
      n_checks++; if (addr !== 32'h40) begin n_fail++; $display("FAIL goto_40: got %h want 40", addr); end
      is_jmp = 1; alu_out = 32'd5; alu_not = 0; imm = 32'h20;
      @(negedge clock);
      n_checks++; if (addr !== 32'h60) begin n_fail++; $display("FAIL br_taken: got %h want 60", addr); end
      go_to(32'h40);
      is_jmp = 1; alu_out = 32'd5; alu_not = 1; imm = 32'h20;
      @(negedge clock);
      n_checks++; if (addr !== 32'h44) begin n_fail++; $display("FAIL br_not_taken: got %h want 44", addr); end
      alu_out = 32'd0;
      @(negedge clock);
      n_checks++; if (addr !== 32'h64) begin n_fail++; $display("FAIL br_inv_zero: got %h want 64", addr); end
      set_idle();
      is_branch = 2'd3;
      @(negedge clock);
      n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL sel3_reset_addr: got %h want 0", addr); end
      set_idle();
   endtask

   task automatic test_hold();
      go_to(32'h10);
      is_branch = 2'd2; alu_out = 32'h203; imem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_checks++; if (addr !== 32'h10) begin n_fail++; $display("FAIL hold_addr%0d: got %h want 10", i, addr); end
         n_checks++; if (imem_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid%0d: got %b want 1", i, imem_valid); end
      end
      imem_ready = 1;
      @(negedge clock);
      set_idle();
`ifdef MISALIGN_TRAP_EN
      n_checks++; if (addr !== 32'h100) begin n_fail++; $display("FAIL hold_mis_addr: got %h want 100", addr); end
      n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL hold_mis_pulse: got %b want 1", misaligned); end
      n_checks++; if (epc !== 32'h10) begin n_fail++; $display("FAIL hold_mis_epc: got %h want 10", epc); end
      @(negedge clock);
`else
      n_checks++; if (addr !== 32'h200) begin n_fail++; $display("FAIL hold_release: got %h want 200", addr); end
      n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL hold_no_mis: got %b want 0", misaligned); end
`endif
   endtask

   task automatic test_trap();
      go_to(32'h80);
      trap = 1; is_branch = 2'd1; imm = 32'h40;
      @(negedge clock);
      n_checks++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL trap_pulse: got %b want 1", trap_taken); end
      n_checks++; if (epc !== 32'h80) begin n_fail++; $display("FAIL trap_epc: got %h want 80", epc); end
      n_checks++; if (addr !== 32'h100) begin n_fail++; $display("FAIL trap_addr: got %h want 100", addr); end
      n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL trap_valid: got %b want 0", imem_valid); end
      // trap still high in TRAP state must be ignored
      @(negedge clock);
      n_checks++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL trap_pulse_end: got %b want 0", trap_taken); end
      n_checks++; if (imem_valid !== 1'b1) begin n_fail++; $display("FAIL trap_refetch_valid: got %b want 1", imem_valid); end
      n_checks++; if (addr !== 32'h100) begin n_fail++; $display("FAIL trap_refetch_addr: got %h want 100", addr); end
      set_idle();
      @(negedge clock);
      n_checks++; if (addr !== 32'h104) begin n_fail++; $display("FAIL trap_next: got %h want 104", addr); end
   endtask

   task automatic test_misalign();
      go_to(32'h20);
      is_branch = 2'd1; imm = 32'd6;
      @(negedge clock);
      set_idle();
`ifdef MISALIGN_TRAP_EN
      n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", misaligned); end
      n_checks++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL mis_trap: got %b want 1", trap_taken); end
      n_checks++; if (epc !== 32'h20) begin n_fail++; $display("FAIL mis_epc: got %h want 20", epc); end
      n_checks++; if (addr !== 32'h100) begin n_fail++; $display("FAIL mis_addr: got %h want 100", addr); end
      @(negedge clock);
      n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end: got %b want 0", misaligned); end
`else
      n_checks++; if (addr !== 32'h24) begin n_fail++; $display("FAIL mis_clear: got %h want 24", addr); end
      n_checks++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL mis_no_trap: got %b want 0", trap_taken); end
      n_checks++; if (epc !== 32'h80) begin n_fail++; $display("FAIL mis_epc_kept: got %h want 80", epc); end
`endif
   endtask

   task automatic test_wrap_stall();
      go_to(32'hFFFF_FFFC);
      @(negedge clock);
      n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL wrap: got %h want 0", addr); end
      @(negedge clock);
      n_checks++; if (addr !== 32'h4) begin n_fail++; $display("FAIL wrap_next: got %h want 4", addr); end
      stall = 1; trap = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         n_checks++; if (addr !== 32'h4) begin n_fail++; $display("FAIL stall_addr%0d: got %h want 4", i, addr); end
         n_checks++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL stall_trap%0d: got %b want 0", i, trap_taken); end
      end
      set_idle();
      @(negedge clock);
      n_checks++; if (addr !== 32'h8) begin n_fail++; $display("FAIL stall_release: got %h want 8", addr); end
   endtask

   task automatic test_reset_mid();
      trap = 1;
      @(negedge clock);
      set_idle();
      n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL mid_in_trap: got %b want 0", imem_valid); end
      reset = 0;
      @(negedge clock);
      n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_addr: got %h want 0", addr); end
      n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL mid_rst_epc: got %h want 0", epc); end
      n_checks++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pulse: got %b want 0", trap_taken); end
      reset = 1; stall = 1;
      @(negedge clock);
      n_checks++; if (imem_valid !== 1'b1) begin n_fail++; $display("FAIL boot_under_stall: got %b want 1", imem_valid); end
      n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL boot_stall_addr: got %h want 0", addr); end
      set_idle();
   endtask

   initial begin
      reset = 0;
      set_idle();
      test_reset();
      test_branch();
      test_hold();
      test_trap();
      test_misalign();
      test_wrap_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
